// File: rtl/pll_loop_ctrl.sv
// Digital PLL loop controller: edge-based phase detector, PI loop filter with
// saturating integrator, and a lock qualifier on the measured phase error.
module pll_loop_ctrl #(
    parameter int bit_count  = 24,
    parameter int ERR_W      = 12,
    parameter int KP_SHIFT   = 4,
    parameter int KI_SHIFT   = 0,
    parameter int LOCK_COUNT = 16,
    parameter int LOCK_TOL   = 1
) (
    input  logic                 sys_clk,
    input  logic                 ext_rst_n,
    input  logic                 ref_in,
    input  logic                 dco_in,
    input  logic                 hold,
    output logic [bit_count-1:0] mod,
    output logic [ERR_W-1:0]     phase_err,
    output logic                 err_valid,
    output logic                 locked
);

    localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam int SH_MAX = (KP_SHIFT > KI_SHIFT) ? KP_SHIFT : KI_SHIFT;
    localparam int SUM_W  = ((bit_count > ERR_W + SH_MAX) ? bit_count : ERR_W + SH_MAX) + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-bit_count+1){1'b0}}, {(bit_count-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-bit_count+1){1'b1}}, {(bit_count-1){1'b0}}};
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        DCO_LEAD = 2'd2
    } state_t;

    // Edge detection: bit 0 = ref, bit 1 = dco
    logic [1:0] sig_in;
    logic [1:0] hist_reg;
    logic [1:0] rise;
    logic       armed_reg;
    logic       ref_rise;
    logic       dco_rise;

    assign sig_in = {dco_in, ref_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            // Suppressed for one cycle after reset so a level already high is not an edge
            assign rise[gi] = armed_reg & sig_in[gi] & ~hist_reg[gi];
        end
    endgenerate

    assign ref_rise = rise[0];
    assign dco_rise = rise[1];

    state_t           state_reg, state_next;
    logic [ERR_W-1:0] cnt_reg, cnt_next;
    logic             err_fire;
    logic [ERR_W-1:0] err_mag;
    logic             err_neg;
    logic [ERR_W-1:0] err_val;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_fire   = 1'b0;
        err_mag    = '0;
        err_neg    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ref_rise && dco_rise) begin
                    err_fire = 1'b1;
                end else if (ref_rise) begin
                    state_next = REF_LEAD;
                    cnt_next   = ERR_W'(1);
                end else if (dco_rise) begin
                    state_next = DCO_LEAD;
                    cnt_next   = ERR_W'(1);
                end
            end
            REF_LEAD: begin
                if (dco_rise) begin
                    err_fire = 1'b1;
                    err_mag  = cnt_reg;
                    if (ref_rise) begin
                        cnt_next = ERR_W'(1);
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else if (ref_rise) begin
                    err_fire = 1'b1;
                    err_mag  = ERR_MAX;
                    cnt_next = ERR_W'(1);
                end else if (cnt_reg == ERR_MAX) begin
                    err_fire   = 1'b1;
                    err_mag    = ERR_MAX;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ERR_W'(1);
                end
            end
            DCO_LEAD: begin
                err_neg = 1'b1;
                if (ref_rise) begin
                    err_fire = 1'b1;
                    err_mag  = cnt_reg;
                    if (dco_rise) begin
                        cnt_next = ERR_W'(1);
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else if (dco_rise) begin
                    err_fire = 1'b1;
                    err_mag  = ERR_MAX;
                    cnt_next = ERR_W'(1);
                end else if (cnt_reg == ERR_MAX) begin
                    err_fire   = 1'b1;
                    err_mag    = ERR_MAX;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + ERR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign err_val = err_neg ? ((~err_mag) + ERR_W'(1)) : err_mag;

    logic [ERR_W-1:0] phase_err_reg;
    logic             err_valid_reg;

    always_ff @(posedge sys_clk) begin
        if (!ext_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hist_reg      <= '0;
            armed_reg     <= 1'b0;
            phase_err_reg <= '0;
            err_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hist_reg      <= sig_in;
            armed_reg     <= 1'b1;
            err_valid_reg <= err_fire;
            if (err_fire) begin
                phase_err_reg <= err_val;
            end
        end
    end

    // Loop filter; sums are wide enough that only the explicit clamp limits them
    function automatic logic signed [SUM_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r = SAT_MIN;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [bit_count-1:0]    integ_reg;
    logic [bit_count-1:0]    mod_reg;
    logic signed [SUM_W-1:0] err_ext;
    logic signed [SUM_W-1:0] integ_ext;
    logic signed [SUM_W-1:0] integ_sat;
    logic signed [SUM_W-1:0] mod_sat;

    assign err_ext   = {{(SUM_W-ERR_W){phase_err_reg[ERR_W-1]}}, phase_err_reg};
    assign integ_ext = {{(SUM_W-bit_count){integ_reg[bit_count-1]}}, integ_reg};
    assign integ_sat = sat(integ_ext + (err_ext <<< KI_SHIFT));
    assign mod_sat   = sat(integ_sat + (err_ext <<< KP_SHIFT));

    always_ff @(posedge sys_clk) begin
        if (!ext_rst_n) begin
            integ_reg <= '0;
            mod_reg   <= '0;
        end else if (err_valid_reg && !hold) begin
            integ_reg <= integ_sat[bit_count-1:0];
            mod_reg   <= mod_sat[bit_count-1:0];
        end
    end

    // Lock qualifier runs regardless of hold
    logic [ERR_W-1:0] err_abs;
    logic             within_tol;
    logic [LCW-1:0]   lock_cnt_reg, lock_cnt_next;
    logic             locked_reg;

    assign err_abs    = phase_err_reg[ERR_W-1] ? ((~phase_err_reg) + ERR_W'(1)) : phase_err_reg;
    assign within_tol = (err_abs <= ERR_W'(LOCK_TOL));

    always_comb begin
        lock_cnt_next = '0;
        if (within_tol) begin
            lock_cnt_next = (lock_cnt_reg == LCW'(LOCK_COUNT)) ? lock_cnt_reg
                                                               : lock_cnt_reg + LCW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!ext_rst_n) begin
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else if (err_valid_reg) begin
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= (lock_cnt_next == LCW'(LOCK_COUNT));
        end
    end

    assign mod       = mod_reg;
    assign phase_err = phase_err_reg;
    assign err_valid = err_valid_reg;
    assign locked    = locked_reg;

endmodule
